vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 94 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Walks a pixel/line raster and produces sync, blanking and end-of-line/frame
// markers. Every output is a register, and all of them describe the same pixel.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        line_end,
    output logic        frame_end,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Both totals must fit the 11-bit counters.
    localparam bit PARAMS_OK = (H_TOTAL <= 2047) && (V_TOTAL <= 2047);

    // Raster landmarks, sized to the counters.
    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
    localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        h_wrap;
    logic [10:0] h_next;
    logic [10:0] v_next;

    // Next raster position: hcount always steps, vcount steps only on the line wrap.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        h_next = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end
    end

    // Register the position and every flag together so the outputs never skew.
    // NOTE: flags are decoded from h_next/v_next, not from hcount/vcount, so the
    // registered flag lands in the same cycle as the position it describes.
    always_ff @(posedge pclk) begin
        // NOTE: non-blocking assignments throughout; every right-hand side sees
        // the pre-edge values regardless of statement order.
        if (rst) begin
            hcount    <= '0;
            vcount    <= '0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            hblnk     <= 1'b0;
            vblnk     <= 1'b0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            hcount    <= h_next;
            vcount    <= v_next;
            hblnk     <= (h_next >= H_BLNK_START);
            vblnk     <= (v_next >= V_BLNK_START);
            hsync     <= (h_next >= H_SYNC_START) && (h_next < H_SYNC_END);
            vsync     <= (v_next >= V_SYNC_START) && (v_next < V_SYNC_END);
            line_end  <= (h_next == H_LAST);
            frame_end <= (h_next == H_LAST) && (v_next == V_LAST);
            // frame_end is high in the cycle being left, so this counts completed frames.
            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Flag parameter sets whose raster totals overflow the 11-bit counters.
    a_params_fit: assert property (@(posedge pclk) PARAMS_OK)
        else $error("vga_timing_gen: H_TOTAL=%0d or V_TOTAL=%0d exceeds 2047", H_TOTAL, V_TOTAL);

endmodule
